nv_ram_rws_64x18_fifo_ctrl: RTL

NV_RAM_RWS_64X18_FIFO_CTRL -- requirements
Module: nv_ram_rws_64x18_fifo_ctrl

---
 rtl/nv_ram_rws_64x18_fifo_ctrl.sv | 80 ++++++++
 1 files changed

// File: rtl/nv_ram_rws_64x18_fifo_ctrl.sv
// FIFO controller for an external 64x18 read/write-separate RAM with a
// one-cycle read latency, backed by a 2-entry output buffer for full throughput.
module nv_ram_rws_64x18_fifo_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [17:0] wr_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic [17:0] rd_data,
  output logic [5:0]  ram_wa,
  output logic        ram_we,
  output logic [17:0] ram_di,
  output logic [5:0]  ram_ra,
  output logic        ram_re,
  input  logic [17:0] ram_dout,
  input  logic [31:0] pwrbus_ram_pd,
  output logic [31:0] ram_pwrbus_ram_pd,
  output logic [6:0]  count
);

  logic [5:0]  wptr;
  logic [5:0]  rptr;
  logic [6:0]  ram_cnt;
  logic        pend;
  logic [1:0]  out_cnt;
  logic [17:0] obuf0;
  logic [17:0] obuf1;
  logic        push;
  logic        pop;
  logic [2:0]  out_need;
  logic        cap_idx;

  assign wr_ready = (ram_cnt < 7'd64);
  assign push     = wr_valid && wr_ready && !rst;
  assign rd_valid = (out_cnt != 2'd0);
  assign rd_data  = obuf0;
  assign pop      = rd_valid && rd_ready;

  assign ram_we = push;
  assign ram_wa = wptr;
  assign ram_di = wr_data;

  // Buffer slots still owed after this cycle: held + in flight - leaving now.
  assign out_need = {1'b0, out_cnt} + {2'b00, pend} - {2'b00, pop};
  assign ram_re   = !rst && (ram_cnt != 7'd0) && (out_need < 3'd2);
  assign ram_ra   = rptr;

  assign ram_pwrbus_ram_pd = pwrbus_ram_pd;
  assign count = ram_cnt + {6'b0, pend} + {5'b0, out_cnt};

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr    <= 6'd0;
      rptr    <= 6'd0;
      ram_cnt <= 7'd0;
      pend    <= 1'b0;
      out_cnt <= 2'd0;
    end else begin
      if (push) wptr <= wptr + 6'd1;
      if (ram_re) rptr <= rptr + 6'd1;
      ram_cnt <= ram_cnt + {6'b0, push} - {6'b0, ram_re};
      pend    <= ram_re;
      out_cnt <= out_cnt + {1'b0, pend} - {1'b0, pop};
    end
  end

  // Capture lands in slot (out_cnt - pop); its low bit is out_cnt[0] ^ pop.
  assign cap_idx = out_cnt[0] ^ pop;

  always_ff @(posedge clk) begin
    if (pop) obuf0 <= obuf1;
    if (pend) begin
      if (cap_idx) obuf1 <= ram_dout;
      else         obuf0 <= ram_dout;
    end
  end

endmodule
